ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Parametrised instruction-fetch unit for the npc core. It succeeds the flat PC register and next-PC adder of the single-cycle top. It owns the PC and issues fetch requests to instruction memory over a valid/ready request channel with a fixed-order response channel. It buffers returned instructions, tagged with their PC, in a small FIFO toward decode, and handles redirects (jal/jalr/branch/trap) and halt (ebreak) without losing or duplicating instructions.

Parameters:
PC_WIDTH, 32, width of PC and fetch address
ILEN, 32, instruction width
RESET_PC, 32'h8000_0000, first fetch address after reset
BUF_DEPTH, 4, instruction FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  PC_WIDTH  fetch address, bits[1:0] always 0
imem_resp_valid_i  in  1  response valid; one response per accepted request, in order, >=1 cycle after acceptance
imem_resp_data_i  in  ILEN  fetched instruction
redirect_valid_i  in  1  one-cycle pulse, next PC comes from redirect_pc_i
redirect_pc_i  in  PC_WIDTH  redirect target; bits[1:0] are ignored and forced to 0
halt_i  in  1  level; while high, no new requests are issued
inst_valid_o  out  1  FIFO head valid
inst_ready_i  in  1  decode consumes head
inst_o  out  ILEN  head instruction
inst_pc_o  out  PC_WIDTH  PC of head instruction

Behaviour:
- Reset is asynchronous, active-low: pc_q=RESET_PC, state=IDLE, FIFO empty, inflight=0. During reset imem_req_valid_o=0 and inst_valid_o=0.
- FSM states: IDLE, FETCH, WAIT, DROP.
  - IDLE -> FETCH on the first clock after reset release.
  - FETCH: imem_req_valid_o = !halt_i && (count + inflight < BUF_DEPTH). imem_req_addr_o = pc_q. On handshake: pc_q <= pc_q+4 (wraps mod 2^PC_WIDTH), inflight=1, go to WAIT.
  - WAIT: no request is issued. On imem_resp_valid_i: push {data, pc of request} into the FIFO, inflight=0, go to FETCH. The same cycle's FETCH condition is not evaluated, so there is at most one outstanding request.
  - DROP: a stale request is in flight. imem_req_valid_o=0. On imem_resp_valid_i the data is discarded, inflight=0, go to FETCH.
- Redirect has priority over every other event in the same cycle:
  - pc_q <= {redirect_pc_i[PC_WIDTH-1:2],2'b00}.
  - The FIFO is flushed: count=0, inst_valid_o=0 next cycle. A same-cycle pop by decode is ignored.
  - Redirect in FETCH without handshake -> FETCH. The request may be withdrawn or change address; imem tolerates this.
  - Redirect in FETCH with a same-cycle handshake -> DROP.
  - Redirect in WAIT without response -> DROP.
  - Redirect in WAIT with a same-cycle response -> response discarded, go to FETCH.
  - Redirect in DROP without response -> stay in DROP. With a response -> FETCH.
- FIFO rules:
  - Push and pop in the same cycle are allowed when the FIFO is full.
  - The request gating guarantees no overflow.
  - Pop on empty is ignored.
  - inst_o and inst_pc_o are registered FIFO head outputs. A response is visible to decode the cycle after imem_resp_valid_i.
- Halt: with halt_i high, FETCH issues nothing. An in-flight response still completes and is pushed. Deasserting halt_i resumes fetch at pc_q.
- Throughput: one instruction per 2 cycles at zero memory wait, because of the single outstanding request.
- Reset mid-operation returns the block to reset values immediately. Any response arriving later is ignored, since inflight=0 and the state is IDLE or FETCH. imem must itself be reset alongside.

Decomposition:
- Shared defines: RESET_PC default, state encoding (IDLE/FETCH/WAIT/DROP), the PC increment constant 4.
- One sub-module, ifu_fifo: parametrised synchronous FIFO (WIDTH=ILEN+PC_WIDTH, DEPTH=BUF_DEPTH). It has push/pop/flush, count, and the same async active-low reset.
- FSM and PC logic stay in ifu_fetch.

Test Plan:
- Reset release, imem ready=1, 1-cycle latency:
  - first request addr=0x8000_0000, then 0x8000_0004, 0x8000_0008.
  - Decode sees inst_pc_o in the same order with matching data.
- inst_ready_i=0, BUF_DEPTH=4:
  - exactly 4 requests issued, then imem_req_valid_o stays 0.
  - Raising ready drains 4 entries and fetch resumes at 0x8000_0010.
- Redirect to 0x8000_0103 during WAIT:
  - the pending response is dropped and the FIFO is flushed.
  - Next request addr=0x8000_0100. The first decoded pc is 0x8000_0100.
- Redirect in the same cycle as a response, and separately in the same cycle as a request handshake:
  - the first case goes to FETCH with no drop.
  - the second enters DROP and discards exactly one later response.
- halt_i asserted while in WAIT:
  - the response is delivered and no further request is issued.
  - Release resumes at the next sequential PC. PC 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- rst_n_i pulsed low mid-WAIT:
  - outputs are 0 immediately, without waiting for a clock.
  - After release the first request addr is 0x8000_0000 and the late response is ignored.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_pkg
// Shared definitions for the npc instruction-fetch unit:
//   RESET_PC_DEFAULT : first fetch address after reset
//   PC_INCR          : sequential PC step (one 32-bit instruction)
//   fetch_state_t    : fetch FSM encoding
// ---------------------------------------------------------------------------
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned PC_INCR          = 4;

    // IDLE  : one cycle after reset release
    // FETCH : may issue a request
    // WAIT  : one request outstanding, its response will be kept
    // DROP  : one request outstanding, its response is stale and discarded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Small synchronous FIFO carrying {instruction, pc} toward decode.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   push_i/push_data_i : write one entry
//   pop_i          : consume head (ignored when empty)
//   flush_i        : empty the FIFO; wins over push and pop
//   head_valid_o/head_data_o : head entry, driven from storage registers
//   count_o        : number of valid entries
// ---------------------------------------------------------------------------
module ifu_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             pop_eff;
    logic             push_eff;

    assign pop_eff  = pop_i && (count_reg != '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_eff = push_i && ((count_reg != CW'(DEPTH)) || pop_eff);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: validity is tracked by count_reg alone.
    always_ff @(posedge clk_i) begin
        if (push_eff && !flush_i) mem_reg[wr_ptr_reg] <= push_data_i;
    end

    assign head_valid_o = (count_reg != '0);
    assign head_data_o  = mem_reg[rd_ptr_reg];
    assign count_o      = count_reg;

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction-fetch unit: owns the PC, issues one fetch request at a time on
// a valid/ready channel, buffers in-order responses tagged with their PC and
// hands them to decode. Redirects flush the buffer and retarget the PC; a
// response to a request issued before the redirect is dropped.
// Ports:
//   clk_i, rst_n_i                 : clock, asynchronous active-low reset
//   imem_req_valid_o/ready_i/addr_o: fetch request channel
//   imem_resp_valid_i/data_i       : in-order fetch response
//   redirect_valid_i/redirect_pc_i : one-cycle PC redirect
//   halt_i                         : level, blocks new requests
//   inst_valid_o/ready_i/inst_o/inst_pc_o : instruction stream to decode
// ---------------------------------------------------------------------------
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned          PC_WIDTH  = 32,
    parameter int unsigned          ILEN      = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned          BUF_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    output logic                imem_req_valid_o,
    input  logic                imem_req_ready_i,
    output logic [PC_WIDTH-1:0] imem_req_addr_o,
    input  logic                imem_resp_valid_i,
    input  logic [ILEN-1:0]     imem_resp_data_i,
    input  logic                redirect_valid_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                halt_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [ILEN-1:0]     inst_o,
    output logic [PC_WIDTH-1:0] inst_pc_o
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned FW = ILEN + PC_WIDTH;

    fetch_state_t        state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [PC_WIDTH-1:0] req_pc_reg, req_pc_next;   // PC of the outstanding request
    logic                inflight_reg, inflight_next;

    logic                req_valid;
    logic                req_fire;
    logic                fifo_push;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         occupancy;
    logic                room_ok;
    logic [PC_WIDTH-1:0] redirect_pc_aligned;
    logic [FW-1:0]       fifo_head;

    // Buffered plus outstanding entries must fit, so a response can never overflow.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg};
    assign room_ok   = occupancy < (CW+1)'(BUF_DEPTH);

    assign redirect_pc_aligned = redirect_pc_i & ~PC_WIDTH'(3);
    assign req_fire            = req_valid && imem_req_ready_i;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        req_pc_next   = req_pc_reg;
        inflight_next = inflight_reg;
        req_valid     = 1'b0;
        fifo_push     = 1'b0;

        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                req_valid = !halt_i && room_ok;
                if (req_fire) begin
                    pc_next       = pc_reg + PC_WIDTH'(PC_INCR);
                    req_pc_next   = pc_reg;
                    inflight_next = 1'b1;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Request gating is not evaluated here: one outstanding request max.
                if (imem_resp_valid_i) begin
                    fifo_push     = 1'b1;
                    inflight_next = 1'b0;
                    state_next    = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (imem_resp_valid_i) begin
                    inflight_next = 1'b0;
                    state_next    = ST_FETCH;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Redirect overrides everything above. Inflight bookkeeping from the
        // case is still correct; only where that request's answer goes changes.
        if (redirect_valid_i) begin
            pc_next   = redirect_pc_aligned;
            fifo_push = 1'b0;
            case (state_reg)
                ST_FETCH: state_next = req_fire ? ST_DROP : ST_FETCH;
                ST_WAIT:  state_next = imem_resp_valid_i ? ST_FETCH : ST_DROP;
                ST_DROP:  state_next = imem_resp_valid_i ? ST_FETCH : ST_DROP;
                default:  state_next = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            req_pc_reg   <= RESET_PC;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_pc_reg   <= req_pc_next;
            inflight_reg <= inflight_next;
        end
    end

    ifu_fifo #(
        .WIDTH (FW),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .push_i       (fifo_push),
        .push_data_i  ({imem_resp_data_i, req_pc_reg}),
        .pop_i        (inst_ready_i),
        .flush_i      (redirect_valid_i),
        .head_valid_o (inst_valid_o),
        .head_data_o  (fifo_head),
        .count_o      (fifo_count)
    );

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_reg;
    assign inst_o           = fifo_head[FW-1:PC_WIDTH];
    assign inst_pc_o        = fifo_head[PC_WIDTH-1:0];

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] imem_resp_data_i = '0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        halt_i = 1'b0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    int total = 0;
    int bad   = 0;

    ifu_fetch #(
        .PC_WIDTH  (32),
        .ILEN      (32),
        .RESET_PC  (32'h8000_0000),
        .BUF_DEPTH (4)
    ) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_pc_i     (redirect_pc_i),
        .halt_i            (halt_i),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .inst_o            (inst_o),
        .inst_pc_o         (inst_pc_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory content is a fixed function of the address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // ---------------- imem model: logs handshakes, answers after mem_lat cycles
    logic [31:0] req_log[$];
    logic [31:0] dec_pc[$];
    logic [31:0] dec_data[$];
    int          mem_lat = 1;
    int          clr_tok = 0;
    logic        m_hs = 1'b0;
    logic [31:0] m_hs_addr = '0;
    int          m_hs_lat = 1;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_addr = '0;
    int          m_pend_cnt = 0;
    int          m_clr_seen = 0;

    always begin
        @(negedge clk_i);
        m_hs = rst_n_i && imem_req_valid_o && imem_req_ready_i;
        if (m_hs) begin
            m_hs_addr = imem_req_addr_o;
            m_hs_lat  = mem_lat;
            req_log.push_back(imem_req_addr_o);
        end
        @(posedge clk_i);
        #1;
        imem_resp_valid_i = 1'b0;
        if (m_hs) begin
            m_pend      = 1'b1;
            m_pend_addr = m_hs_addr;
            m_pend_cnt  = m_hs_lat;
        end
        if (m_clr_seen != clr_tok) begin
            m_clr_seen = clr_tok;
            m_pend     = 1'b0;
        end
        if (m_pend) begin
            if (m_pend_cnt <= 1) begin
                imem_resp_valid_i = 1'b1;
                imem_resp_data_i  = inst_of(m_pend_addr);
                m_pend            = 1'b0;
            end else begin
                m_pend_cnt--;
            end
        end
    end

    // Decode side: record every accepted instruction.
    always @(negedge clk_i) begin
        if (rst_n_i && inst_valid_o && inst_ready_i && !redirect_valid_i) begin
            dec_pc.push_back(inst_pc_o);
            dec_data.push_back(inst_o);
        end
    end

    function automatic logic [63:0] req_at(input int i);
        if (i < req_log.size()) return {32'h0, req_log[i]};
        return 64'hDEAD_0000_0000_0000;
    endfunction
    function automatic logic [63:0] dpc_at(input int i);
        if (i < dec_pc.size()) return {32'h0, dec_pc[i]};
        return 64'hDEAD_0000_0000_0000;
    endfunction
    function automatic logic [63:0] ddat_at(input int i);
        if (i < dec_data.size()) return {32'h0, dec_data[i]};
        return 64'hDEAD_0000_0000_0000;
    endfunction

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Returns at the negedge before an edge where a handshake will occur.
    task automatic wait_req_neg(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk_i);
            if (imem_req_valid_o && imem_req_ready_i) seen = 1'b1;
        end
        check_val({tag, "_hs"}, {63'h0, seen}, 64'h1);
    endtask

    task automatic wait_req_hs(input string tag);
        wait_req_neg(tag);
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = pc;
        @(posedge clk_i);
        #1;
        redirect_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_i          = 1'b0;
        clr_tok++;
        redirect_valid_i = 1'b0;
        halt_i           = 1'b0;
        imem_req_ready_i = 1'b0;
        inst_ready_i     = 1'b0;
        mem_lat          = 1;
        repeat (2) @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb;
        int db;

        // ---- reset state and first request
        #12;
        check_val("rst_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
        check_val("rst_inst_valid", {63'h0, inst_valid_o}, 64'h0);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
        #1;
        check_val("idle_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
        @(posedge clk_i);
        #1;
        check_val("fetch_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
        check_val("fetch_addr0", {32'h0, imem_req_addr_o}, 64'h8000_0000);

        // ---- sequential stream, zero-wait memory
        rb = req_log.size();
        db = dec_pc.size();
        imem_req_ready_i = 1'b1;
        inst_ready_i     = 1'b1;
        run(10);
        check_val("seq_nreq", 64'(req_log.size() - rb), 64'd5);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("seq_req%0d", i), req_at(rb + i), {32'h0, 32'h8000_0000 + 32'(4 * i)});
            check_val($sformatf("seq_dpc%0d", i), dpc_at(db + i), {32'h0, 32'h8000_0000 + 32'(4 * i)});
            check_val($sformatf("seq_dat%0d", i), ddat_at(db + i), {32'h0, inst_of(32'h8000_0000 + 32'(4 * i))});
        end

        // ---- backpressure fills the buffer, then drains
        do_reset();
        rb = req_log.size();
        db = dec_pc.size();
        imem_req_ready_i = 1'b1;
        run(20);
        check_val("bp_nreq", 64'(req_log.size() - rb), 64'd4);
        check_val("bp_req3", req_at(rb + 3), 64'h8000_000C);
        check_val("bp_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
        check_val("bp_inst_valid", {63'h0, inst_valid_o}, 64'h1);
        check_val("bp_head_pc", {32'h0, inst_pc_o}, 64'h8000_0000);
        inst_ready_i = 1'b1;
        run(20);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("bp_dpc%0d", i), dpc_at(db + i), {32'h0, 32'h8000_0000 + 32'(4 * i)});
        check_val("bp_req4", req_at(rb + 4), 64'h8000_0010);
        check_val("bp_dpc4", dpc_at(db + 4), 64'h8000_0010);

        // ---- redirect during WAIT: drop pending response, flush buffer
        do_reset();
        imem_req_ready_i = 1'b1;
        wait_req_hs("rw_a");
        wait_req_hs("rw_b");
        mem_lat = 3;
        wait_req_hs("rw_c");
        check_val("rw_pre_valid", {63'h0, inst_valid_o}, 64'h1);
        pulse_redirect(32'h8000_0103);
        rb = req_log.size();
        db = dec_pc.size();
        check_val("rw_flush", {63'h0, inst_valid_o}, 64'h0);
        check_val("rw_drop_noreq", {63'h0, imem_req_valid_o}, 64'h0);
        inst_ready_i = 1'b1;
        run(12);
        check_val("rw_req", req_at(rb), 64'h8000_0100);
        check_val("rw_dpc", dpc_at(db), 64'h8000_0100);
        check_val("rw_dat", ddat_at(db), {32'h0, inst_of(32'h8000_0100)});

        // ---- redirect in the same cycle as a response
        do_reset();
        imem_req_ready_i = 1'b1;
        wait_req_hs("rr");
        pulse_redirect(32'h8000_0200);
        check_val("rr_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
        check_val("rr_addr", {32'h0, imem_req_addr_o}, 64'h8000_0200);
        check_val("rr_inst_valid", {63'h0, inst_valid_o}, 64'h0);
        rb = req_log.size();
        db = dec_pc.size();
        inst_ready_i = 1'b1;
        run(8);
        check_val("rr_req", req_at(rb), 64'h8000_0200);
        check_val("rr_dpc", dpc_at(db), 64'h8000_0200);

        // ---- redirect in the same cycle as a request handshake
        do_reset();
        imem_req_ready_i = 1'b1;
        wait_req_hs("rh_a");
        wait_req_neg("rh_b");
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0300;
        @(posedge clk_i);
        #1;
        redirect_valid_i = 1'b0;
        check_val("rh_drop_noreq", {63'h0, imem_req_valid_o}, 64'h0);
        check_val("rh_flush", {63'h0, inst_valid_o}, 64'h0);
        run(1);
        check_val("rh_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
        check_val("rh_addr", {32'h0, imem_req_addr_o}, 64'h8000_0300);
        db = dec_pc.size();
        inst_ready_i = 1'b1;
        run(8);
        check_val("rh_dpc0", dpc_at(db), 64'h8000_0300);
        check_val("rh_dat0", ddat_at(db), {32'h0, inst_of(32'h8000_0300)});
        check_val("rh_dpc1", dpc_at(db + 1), 64'h8000_0304);

        // ---- halt while WAIT, PC wraparound on resume
        do_reset();
        inst_ready_i = 1'b1;
        run(2);
        pulse_redirect(32'hFFFF_FFFC);
        rb = req_log.size();
        db = dec_pc.size();
        check_val("hl_addr", {32'h0, imem_req_addr_o}, 64'hFFFF_FFFC);
        imem_req_ready_i = 1'b1;
        wait_req_hs("hl_a");
        halt_i = 1'b1;
        run(8);
        check_val("hl_nreq", 64'(req_log.size() - rb), 64'd1);
        check_val("hl_ndec", 64'(dec_pc.size() - db), 64'd1);
        check_val("hl_dpc", dpc_at(db), 64'hFFFF_FFFC);
        check_val("hl_dat", ddat_at(db), {32'h0, inst_of(32'hFFFF_FFFC)});
        check_val("hl_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
        halt_i = 1'b0;
        wait_req_hs("hl_b");
        check_val("hl_wrap", req_at(rb + 1), 64'h0000_0000);

        // ---- asynchronous reset mid-WAIT with a late response
        do_reset();
        imem_req_ready_i = 1'b1;
        wait_req_hs("ar_a");
        mem_lat = 3;
        wait_req_hs("ar_b");
        imem_req_ready_i = 1'b0;
        check_val("ar_pre_valid", {63'h0, inst_valid_o}, 64'h1);
        #3;
        rst_n_i = 1'b0;
        #1;
        check_val("ar_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
        check_val("ar_inst_valid", {63'h0, inst_valid_o}, 64'h0);
        #2;
        rst_n_i = 1'b1;
        rb = req_log.size();
        run(5);
        check_val("ar_late_ignored", {63'h0, inst_valid_o}, 64'h0);
        check_val("ar_fetch_valid", {63'h0, imem_req_valid_o}, 64'h1);
        check_val("ar_fetch_addr", {32'h0, imem_req_addr_o}, 64'h8000_0000);
        mem_lat = 1;
        imem_req_ready_i = 1'b1;
        inst_ready_i = 1'b1;
        db = dec_pc.size();
        run(8);
        check_val("ar_req", req_at(rb), 64'h8000_0000);
        check_val("ar_dpc", dpc_at(db), 64'h8000_0000);
        check_val("ar_dat", ddat_at(db), {32'h0, inst_of(32'h8000_0000)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
